hex_ascii_formatter: RTL and testbench
======================================

HEX_ASCII_FORMATTER -- requirements
Module: hex_ascii_formatter

Interface
REQ-001 SHALL have parameter BYTES_PER_LINE, default 16: number of bytes per output line before CR LF is inserted; legal range 1..255.
REQ-002 SHALL have parameter UPPERCASE, default 1: 1 selects hex digits 'A'-'F', 0 selects 'a'-'f'.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port i_tready, output, 1: high when an input byte can be accepted.
REQ-006 SHALL have port i_tvalid, input, 1: input byte valid.
REQ-007 SHALL have port i_tdata, input, 8: input byte.
REQ-008 SHALL have port i_tlast, input, 1: input byte ends a packet.
REQ-009 SHALL have port o_tready, input, 1: downstream (uart_tx) can accept a character.
REQ-010 SHALL have port o_tvalid, output, 1: output ASCII character valid.
REQ-011 SHALL have port o_tdata, output, 8: output ASCII character.

Function
REQ-012 SHALL use FSM states IDLE, HI, LO, SEP, CR, LF.
REQ-013 SHALL drive i_tready high only in IDLE, and o_tvalid high only in HI, LO, SEP, CR and LF.
REQ-014 SHALL, in IDLE with i_tvalid=1, latch i_tdata and i_tlast, increment the column counter, and go to HI on the same edge.
REQ-015 SHALL output in HI the ASCII hex of latched byte [7:4], and in LO the ASCII hex of [3:0]: nibbles 0-9 map to 0x30-0x39, 10-15 map to 0x41-0x46 (UPPERCASE=1) or 0x61-0x66 (UPPERCASE=0).
REQ-016 SHALL output 0x20 in SEP, 0x0D in CR and 0x0A in LF.
REQ-017 SHALL advance from a valid state only on the edge where o_tvalid=1 and o_tready=1, and hold state and o_tdata unchanged otherwise.
REQ-018 SHALL transition HI->LO, and LO->CR when latched tlast=1 or column counter == BYTES_PER_LINE; otherwise LO->SEP.
REQ-019 SHALL transition SEP->IDLE, CR->LF, and LF->IDLE, clearing the column counter on LF acceptance.
REQ-020 SHALL provide latency of exactly one cycle: a byte accepted at edge N gives o_tvalid=1 with its HI character from edge N onward.
REQ-021 SHALL sustain 3 characters plus 1 IDLE cycle per byte (SEP path) with o_tready held high, i.e. 1 byte per 4 cycles.
REQ-022 SHALL size the column counter as $clog2(BYTES_PER_LINE+1) bits; it never exceeds BYTES_PER_LINE.
REQ-023 SHALL, when BYTES_PER_LINE=1, emit CR LF after every byte.
REQ-024 SHALL let tlast=1 on the byte that also reaches BYTES_PER_LINE produce a single CR LF, not two.
REQ-025 SHALL ignore i_tdata and i_tlast whenever i_tready=0.

Reset
REQ-026 SHALL, while rst=1, force state IDLE, column counter 0, latched byte 0x00, latched tlast 0, o_tvalid=0, o_tdata=0x00 and i_tready=1.
REQ-027 SHALL abandon any partially emitted byte or line on a mid-operation reset; no remaining characters are output after release.
REQ-028 SHALL accept a byte on the first rising edge after rst deasserts when i_tvalid=1.

Verification
REQ-029 SHALL pass this case: BYTES_PER_LINE=16, o_tready=1, byte 0x3A with tlast=0 -> outputs 0x33, 0x41, 0x20, then i_tready=1.
REQ-030 SHALL pass this case: byte 0xFF with tlast=1 -> outputs 0x46, 0x46, 0x0D, 0x0A; with UPPERCASE=0 -> outputs 0x66, 0x66, 0x0D, 0x0A.
REQ-031 SHALL pass this case: bytes 0x00..0x10 streamed with tlast=0 -> 15 SEP characters, then CR LF after byte 0x0F, and byte 0x10 starts a new line with column counter 1.
REQ-032 SHALL pass this case: o_tready held low for 5 cycles while in LO -> o_tvalid=1 and o_tdata constant for all 5 cycles, i_tready=0, and no character is lost or duplicated after release.
REQ-033 SHALL pass this case: rst pulsed while in CR -> o_tvalid=0 and i_tready=1 immediately, no LF is emitted, and the next byte 0x5A outputs 0x35, 0x41 with column counter 1.
REQ-034 SHALL pass this case: random i_tvalid/o_tready stress of 10k bytes -> decoded output stream matches the reference model byte for byte, including line breaks.

Source files
------------

// File: rtl/hex_ascii_formatter.sv
// ---------------------------------------------------------------------------
// hex_ascii_formatter
//
// Turns a stream of raw bytes into printable hex text for a UART-style sink.
// Each byte becomes two hex digits. A space follows the digits unless the
// byte ends a line. A line ends when the byte carries tlast or when it fills
// the line (BYTES_PER_LINE bytes); the line then ends with CR LF instead of
// the space.
//
// Parameters
//   BYTES_PER_LINE : bytes per line before CR LF is inserted (1..255)
//   UPPERCASE      : 1 -> 'A'-'F', 0 -> 'a'-'f'
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   i_tready   : out, a byte can be accepted (only while idle)
//   i_tvalid   : in,  input byte valid
//   i_tdata    : in,  input byte
//   i_tlast    : in,  input byte ends a packet (forces CR LF after it)
//   o_tready   : in,  downstream can take a character
//   o_tvalid   : out, o_tdata holds a character
//   o_tdata    : out, ASCII character
// ---------------------------------------------------------------------------
module hex_ascii_formatter #(
  parameter int BYTES_PER_LINE = 16,
  parameter int UPPERCASE      = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       i_tready,
  input  logic       i_tvalid,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       o_tready,
  output logic       o_tvalid,
  output logic [7:0] o_tdata
);

  localparam int                COL_W   = $clog2(BYTES_PER_LINE + 1);
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(BYTES_PER_LINE);

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    SEP  = 3'd3,
    CR   = 3'd4,
    LF   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_byte;
  logic             r_last;
  logic [COL_W-1:0] r_col;

  logic             w_accept;
  logic             w_lf_done;
  logic             w_line_end;

  // Nibble to ASCII hex digit. 'A' - 10 = 0x37, 'a' - 10 = 0x57.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] base;
    if (nib < 4'd10) begin
      base = 8'h30;
    end else if (UPPERCASE != 0) begin
      base = 8'h37;
    end else begin
      base = 8'h57;
    end
    hex_char = base + {4'h0, nib};
  endfunction

  // The counter already includes the current byte by the time LO is shown,
  // so a byte that both fills the line and carries tlast ends it only once.
  assign w_line_end = r_last || (r_col == COL_MAX);

  assign w_accept   = (r_state == IDLE) && i_tvalid;
  assign w_lf_done  = (r_state == LF) && o_tready;

  // Next state and outputs. Outputs depend on state and latched byte only,
  // so a stalled character stays put until the sink takes it.
  always_comb begin
    w_state_nxt = r_state;
    i_tready    = 1'b0;
    o_tvalid    = 1'b0;
    o_tdata     = 8'h00;
    case (r_state)
      IDLE: begin
        i_tready = 1'b1;
        if (i_tvalid) begin
          w_state_nxt = HI;
        end
      end
      HI: begin
        o_tvalid = 1'b1;
        o_tdata  = hex_char(r_byte[7:4]);
        if (o_tready) begin
          w_state_nxt = LO;
        end
      end
      LO: begin
        o_tvalid = 1'b1;
        o_tdata  = hex_char(r_byte[3:0]);
        if (o_tready) begin
          w_state_nxt = w_line_end ? CR : SEP;
        end
      end
      SEP: begin
        o_tvalid = 1'b1;
        o_tdata  = ASCII_SP;
        if (o_tready) begin
          w_state_nxt = IDLE;
        end
      end
      CR: begin
        o_tvalid = 1'b1;
        o_tdata  = ASCII_CR;
        if (o_tready) begin
          w_state_nxt = LF;
        end
      end
      LF: begin
        o_tvalid = 1'b1;
        o_tdata  = ASCII_LF;
        if (o_tready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, latched byte and column counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_byte  <= 8'h00;
      r_last  <= 1'b0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_byte <= i_tdata;
        r_last <= i_tlast;
        r_col  <= r_col + COL_W'(1);
      end else if (w_lf_done) begin
        r_col  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hex_ascii_formatter.sv
// ---------------------------------------------------------------------------
// Bench for hex_ascii_formatter. Two instances share the input stimulus and
// o_tready: dut0 uses the defaults (16 bytes/line, uppercase), dut1 uses one
// byte per line with lowercase digits. Directed cases come first, followed
// by a randomized run scored against a text-level reference model.
// ---------------------------------------------------------------------------
module tb_hex_ascii_formatter;

  logic       clk;
  logic       rst;
  logic       i_tvalid;
  logic [7:0] i_tdata;
  logic       i_tlast;
  logic       o_tready;

  logic       i_tready0, o_tvalid0;
  logic [7:0] o_tdata0;
  logic       i_tready1, o_tvalid1;
  logic [7:0] o_tdata1;

  int total = 0;
  int bad   = 0;

  hex_ascii_formatter #(.BYTES_PER_LINE(16), .UPPERCASE(1)) dut0 (
    .clk(clk), .rst(rst),
    .i_tready(i_tready0), .i_tvalid(i_tvalid), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .o_tready(o_tready), .o_tvalid(o_tvalid0), .o_tdata(o_tdata0)
  );

  hex_ascii_formatter #(.BYTES_PER_LINE(1), .UPPERCASE(0)) dut1 (
    .clk(clk), .rst(rst),
    .i_tready(i_tready1), .i_tvalid(i_tvalid), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .o_tready(o_tready), .o_tvalid(o_tvalid1), .o_tdata(o_tdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model (text level) ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         mcol[2];
  int         n_acc[2];
  bit         stall_prev[2];
  logic [7:0] prev_dat[2];
  bit         mon_en = 0;

  task automatic model_accept(input int w, input logic [7:0] b, input logic last);
    string      hx;
    int         bpl;
    logic [7:0] chars[$];
    bpl = (w == 0) ? 16 : 1;
    hx  = (w == 0) ? "0123456789ABCDEF" : "0123456789abcdef";
    chars.push_back(hx[int'(b) / 16]);
    chars.push_back(hx[int'(b) % 16]);
    mcol[w] = mcol[w] + 1;
    if (last || mcol[w] == bpl) begin
      chars.push_back(8'h0D);
      chars.push_back(8'h0A);
      mcol[w] = 0;
    end else begin
      chars.push_back(8'h20);
    end
    foreach (chars[k]) begin
      if (w == 0) q0.push_back(chars[k]);
      else        q1.push_back(chars[k]);
    end
  endtask

  task automatic monitor_port(input int w, input logic irdy, input logic ovld,
                              input logic [7:0] odat);
    logic [7:0] e;
    if (stall_prev[w]) begin
      chk($sformatf("hold_vld%0d", w), ovld, 1);
      chk($sformatf("hold_dat%0d", w), odat, prev_dat[w]);
    end
    chk($sformatf("rdy_vs_vld%0d", w), irdy, !ovld);
    if (i_tvalid && irdy) begin
      model_accept(w, i_tdata, i_tlast);
      n_acc[w]++;
    end
    if (ovld && o_tready) begin
      if (w == 0 && q0.size() == 0 || w == 1 && q1.size() == 0) begin
        chk($sformatf("extra_char%0d", w), {24'h0, odat}, 32'h100);
      end else begin
        e = (w == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("char%0d", w), odat, e);
      end
    end
    stall_prev[w] = ovld && !o_tready;
    prev_dat[w]   = odat;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      monitor_port(0, i_tready0, o_tvalid0, o_tdata0);
      monitor_port(1, i_tready1, o_tvalid1, o_tdata1);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      mcol[k] = 0; n_acc[k] = 0; stall_prev[k] = 0; prev_dat[k] = 8'h00;
    end
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] got[$];
    logic [7:0] expq[$];
    string      hx;
    int         idx;
    int         cyc;
    bit         acc;

    rst = 1'b1; i_tvalid = 1'b0; i_tdata = 8'h00; i_tlast = 1'b0; o_tready = 1'b1;
    step();
    step();
    // reset state
    chk("rst_itready", i_tready0, 1);
    chk("rst_otvalid", o_tvalid0, 0);
    chk("rst_otdata",  o_tdata0, 8'h00);
    chk("rst_col",     dut0.r_col, 0);
    rst = 1'b0;

    // 0x3A, no tlast: "3A " (dut1: "3a" CR LF, one byte per line)
    i_tvalid = 1'b1; i_tdata = 8'h3A; i_tlast = 1'b0;
    step();
    i_tvalid = 1'b0;
    chk("r29_hi_vld", o_tvalid0, 1);
    chk("r29_hi",     o_tdata0, 8'h33);
    chk("r29_hi_rdy", i_tready0, 0);
    chk("bpl1_hi",    o_tdata1, 8'h33);
    step();
    chk("r29_lo",     o_tdata0, 8'h41);
    chk("bpl1_lo",    o_tdata1, 8'h61);
    step();
    chk("r29_sep",    o_tdata0, 8'h20);
    chk("bpl1_cr",    o_tdata1, 8'h0D);
    step();
    chk("r29_idle",   i_tready0, 1);
    chk("r29_novld",  o_tvalid0, 0);
    chk("bpl1_lf",    o_tdata1, 8'h0A);
    step();
    chk("bpl1_idle",  i_tready1, 1);

    // 0xFF with tlast: "FF" CR LF / "ff" CR LF
    do_reset();
    i_tvalid = 1'b1; i_tdata = 8'hFF; i_tlast = 1'b1;
    step();
    i_tvalid = 1'b0; i_tlast = 1'b0;
    chk("r30_hi_u", o_tdata0, 8'h46);  chk("r30_hi_l", o_tdata1, 8'h66);
    step();
    chk("r30_lo_u", o_tdata0, 8'h46);  chk("r30_lo_l", o_tdata1, 8'h66);
    step();
    chk("r30_cr_u", o_tdata0, 8'h0D);  chk("r30_cr_l", o_tdata1, 8'h0D);
    step();
    chk("r30_lf_u", o_tdata0, 8'h0A);  chk("r30_lf_l", o_tdata1, 8'h0A);
    step();
    chk("r30_idle", i_tready0, 1);
    chk("r30_col0", dut0.r_col, 0);

    // bytes 0x00..0x10 back to back: line break after 0x0F
    do_reset();
    got.delete();
    idx = 0;
    cyc = 0;
    while ((idx < 17 || o_tvalid0) && cyc < 300) begin
      i_tvalid = (idx < 17);
      i_tdata  = idx[7:0];
      i_tlast  = 1'b0;
      acc = i_tvalid && i_tready0;
      if (o_tvalid0) got.push_back(o_tdata0);
      step();
      if (acc) idx++;
      cyc++;
    end
    i_tvalid = 1'b0;
    chk("r31_timeout", (cyc < 300), 1);
    hx = "0123456789ABCDEF";
    expq.delete();
    for (int b = 0; b < 17; b++) begin
      expq.push_back(hx[b / 16]);
      expq.push_back(hx[b % 16]);
      if (b == 15) begin
        expq.push_back(8'h0D);
        expq.push_back(8'h0A);
      end else begin
        expq.push_back(8'h20);
      end
    end
    chk("r31_len", got.size(), expq.size());
    for (int k = 0; k < expq.size() && k < got.size(); k++) begin
      chk($sformatf("r31_c%0d", k), got[k], expq[k]);
    end
    chk("r31_col", dut0.r_col, 1);

    // stall for 5 cycles in LO with byte 0x7C
    do_reset();
    i_tvalid = 1'b1; i_tdata = 8'h7C; i_tlast = 1'b0;
    step();
    i_tvalid = 1'b0;
    chk("r32_hi", o_tdata0, 8'h37);
    step();
    o_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("r32_vld%0d", k), o_tvalid0, 1);
      chk($sformatf("r32_dat%0d", k), o_tdata0, 8'h43);
      chk($sformatf("r32_rdy%0d", k), i_tready0, 0);
      step();
    end
    o_tready = 1'b1;
    chk("r32_rel", o_tdata0, 8'h43);
    step();
    chk("r32_sep", o_tdata0, 8'h20);
    step();
    chk("r32_idle", i_tready0, 1);

    // reset pulse while in CR
    do_reset();
    i_tvalid = 1'b1; i_tdata = 8'h41; i_tlast = 1'b1;
    step();
    i_tvalid = 1'b0; i_tlast = 1'b0;
    step();
    step();
    chk("r33_cr", o_tdata0, 8'h0D);
    rst = 1'b1;
    #1;
    chk("r33_vld",  o_tvalid0, 0);
    chk("r33_rdy",  i_tready0, 1);
    chk("r33_dat",  o_tdata0, 8'h00);
    step();
    rst = 1'b0;
    i_tvalid = 1'b1; i_tdata = 8'h5A; i_tlast = 1'b0;
    step();
    i_tvalid = 1'b0;
    chk("r33_hi",  o_tdata0, 8'h35);
    chk("r33_col", dut0.r_col, 1);
    step();
    chk("r33_lo",  o_tdata0, 8'h41);
    step();
    chk("r33_sep", o_tdata0, 8'h20);
    step();
    chk("r33_idle", i_tready0, 1);

    // randomized stress against the reference model
    do_reset();
    mon_en = 1;
    cyc = 0;
    while (n_acc[0] < 10000 && cyc < 90000) begin
      i_tvalid = ($urandom % 16) != 0;
      i_tdata  = 8'($urandom);
      i_tlast  = ($urandom % 16) == 0;
      o_tready = ($urandom % 16) != 0;
      step();
      cyc++;
    end
    chk("rand_timeout", (n_acc[0] >= 10000), 1);
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (20) step();
    mon_en = 0;
    chk("rand_drain0", q0.size(), 0);
    chk("rand_drain1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
